// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider with a glitch-free CPU clock mux and single-step mode.
// Divisor writes take effect at the channel's next wrap; source switches park clk_cpu low in between.
module clk_div_prog #(
  parameter int CNT_W   = 32,
  parameter int NCH     = 2,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 15,
  parameter int STEP_HI = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] clkdiv,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  input  logic [2:0]       sel,
  input  logic             step,
  output logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   ch_out,
  output logic             clk_cpu,
  output logic             busy
);

  localparam int HW = $clog2(STEP_HI + 1);
  localparam logic [HW-1:0] HMAX = HW'(STEP_HI - 1);

  typedef enum logic [2:0] {S_RUN, S_DRAIN, S_HOLD, S_STEP_IDLE, S_STEP_HI} state_t;

  logic [DIV_W-1:0] div_act  [NCH];
  logic [DIV_W-1:0] div_pend [NCH];
  logic [DIV_W-1:0] cnt      [NCH];

  state_t          state, state_nxt;
  logic [2:0]      cur, cur_nxt, req_ch;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic            pend, pend_nxt;
  logic            clk_cpu_nxt, req_step, cur_out, cur_rise, step_rise, step_q;
  logic [1:0]      step_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkdiv  <= '0;
      cfg_ack <= 1'b0;
    end else begin
      clkdiv  <= clkdiv + CNT_W'(1);
      cfg_ack <= cfg_wr;
    end
  end

  // Pending divisor is promoted only at a wrap, so a half-period is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_en  <= '0;
      ch_out <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        div_act[i]  <= DIV_W'(DIV_RST);
        div_pend[i] <= DIV_W'(DIV_RST);
        cnt[i]      <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cnt[i] == div_act[i]) begin
          cnt[i]     <= '0;
          ch_en[i]   <= 1'b1;
          ch_out[i]  <= ~ch_out[i];
          div_act[i] <= div_pend[i];
        end else begin
          cnt[i]   <= cnt[i] + DIV_W'(1);
          ch_en[i] <= 1'b0;
        end
        if (cfg_wr && (32'(cfg_ch) == i))
          div_pend[i] <= cfg_div;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync <= '0;
      step_q    <= 1'b0;
    end else begin
      step_sync <= {step_sync[0], step};
      step_q    <= step_sync[1];
    end
  end

  assign step_rise = step_sync[1] & ~step_q;
  assign req_step  = (sel == 3'd7);
  assign req_ch    = (32'(sel) < NCH) ? sel : '0;

  always_comb begin
    cur_out  = 1'b0;
    cur_rise = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(cur) == i) begin
        cur_out  = ch_out[i];
        cur_rise = ch_en[i] & ch_out[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      cur     <= '0;
      hcnt    <= '0;
      pend    <= 1'b0;
      clk_cpu <= 1'b0;
    end else begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      hcnt    <= hcnt_nxt;
      pend    <= pend_nxt;
      clk_cpu <= clk_cpu_nxt;
    end
  end

  // HOLD always targets cur, so cur is switched to the requested channel on entry.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    hcnt_nxt  = hcnt;
    pend_nxt  = pend;
    case (state)
      S_RUN: begin
        if (req_step || (req_ch != cur))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!clk_cpu) begin
          if (req_step) begin
            state_nxt = S_STEP_IDLE;
            hcnt_nxt  = '0;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = S_HOLD;
            cur_nxt   = req_ch;
          end
        end
      end
      S_HOLD: begin
        if (req_step) begin
          state_nxt = S_STEP_IDLE;
          hcnt_nxt  = '0;
          pend_nxt  = 1'b0;
        end else if (req_ch != cur) begin
          cur_nxt = req_ch;
        end else if (cur_rise) begin
          state_nxt = S_RUN;
        end
      end
      S_STEP_IDLE: begin
        if (!req_step) begin
          state_nxt = S_HOLD;
          cur_nxt   = req_ch;
        end else begin
          if (hcnt != HMAX)
            hcnt_nxt = hcnt + HW'(1);
          // A step arriving before the low phase is long enough waits in pend.
          if ((step_rise || pend) && (hcnt == HMAX)) begin
            state_nxt = S_STEP_HI;
            hcnt_nxt  = '0;
            pend_nxt  = 1'b0;
          end else if (step_rise) begin
            pend_nxt = 1'b1;
          end
        end
      end
      S_STEP_HI: begin
        if (hcnt == HMAX) begin
          state_nxt = S_STEP_IDLE;
          hcnt_nxt  = '0;
        end else begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    clk_cpu_nxt = 1'b0;
    busy        = (state == S_DRAIN) || (state == S_HOLD);
    case (state)
      S_RUN:       clk_cpu_nxt = cur_out;
      S_DRAIN:     clk_cpu_nxt = clk_cpu & cur_out;
      S_HOLD:      clk_cpu_nxt = (state_nxt == S_RUN);
      S_STEP_IDLE: clk_cpu_nxt = (state_nxt == S_STEP_HI);
      S_STEP_HI:   clk_cpu_nxt = (state_nxt == S_STEP_HI);
      default:     clk_cpu_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: default timing table, then retune, invalid write,
// source switch, step mode and reset-during-HOLD sequences.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] clkdiv;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic        cfg_ack;
  logic [2:0]  sel = '0;
  logic        step = 1'b0;
  logic [1:0]  ch_en, ch_out;
  logic        clk_cpu, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  clk_div_prog #(.CNT_W(32), .NCH(2), .DIV_W(16), .DIV_RST(15), .STEP_HI(4)) dut (
    .clk(clk), .rst(rst), .clkdiv(clkdiv),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ack(cfg_ack),
    .sel(sel), .step(step), .ch_en(ch_en), .ch_out(ch_out),
    .clk_cpu(clk_cpu), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] div;
    logic [1:0]  en;
    logic [1:0]  out;
    logic        cpu;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    cfg_wr = 1'b0;
    sel    = '0;
    step   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    vecs[0] = '{1,  32'd1,  2'b00, 2'b00, 1'b0};
    vecs[1] = '{15, 32'd15, 2'b00, 2'b00, 1'b0};
    vecs[2] = '{16, 32'd16, 2'b11, 2'b11, 1'b0};
    vecs[3] = '{17, 32'd17, 2'b00, 2'b11, 1'b1};
    vecs[4] = '{31, 32'd31, 2'b00, 2'b11, 1'b1};
    vecs[5] = '{32, 32'd32, 2'b11, 2'b00, 1'b1};
    vecs[6] = '{33, 32'd33, 2'b00, 2'b00, 1'b0};
    vecs[7] = '{48, 32'd48, 2'b11, 2'b11, 1'b0};
    vecs[8] = '{49, 32'd49, 2'b00, 2'b11, 1'b1};

    // Reset values while rst is held
    tick();
    chk("rst_clkdiv", 64'(clkdiv), 64'd0);
    chk("rst_ch_en", 64'(ch_en), 64'd0);
    chk("rst_ch_out", 64'(ch_out), 64'd0);
    chk("rst_ack", 64'(cfg_ack), 64'd0);
    chk("rst_clk_cpu", 64'(clk_cpu), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Default divisors
    do_reset();
    foreach (vecs[j]) begin
      run_to(vecs[j].cyc);
      chk("def_clkdiv", 64'(clkdiv), 64'(vecs[j].div));
      chk("def_ch_en", 64'(ch_en), 64'(vecs[j].en));
      chk("def_ch_out", 64'(ch_out), 64'(vecs[j].out));
      chk("def_clk_cpu", 64'(clk_cpu), 64'(vecs[j].cpu));
      chk("def_busy", 64'(busy), 64'd0);
    end

    // Retune ch0 to 3 mid-period
    do_reset();
    run_to(8);
    cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd3;
    tick();
    cfg_wr = 1'b0;
    chk("retune_ack", 64'(cfg_ack), 64'd1);
    tick();
    chk("retune_ack_off", 64'(cfg_ack), 64'd0);
    for (int k = 11; k <= 31; k++) begin
      logic e_out, e_en;
      run_to(k);
      e_out = (k >= 16) && ((((k - 16) / 4) % 2) == 0);
      e_en  = (k == 16) || (k == 20) || (k == 24) || (k == 28);
      chk("retune_out0", 64'(ch_out[0]), 64'(e_out));
      chk("retune_en0", 64'(ch_en[0]), 64'(e_en));
      chk("retune_out1", 64'(ch_out[1]), 64'(k >= 16));
    end

    // Invalid channel writes leave all divisors alone
    do_reset();
    run_to(5);
    cfg_wr = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd0;
    tick();
    cfg_wr = 1'b0;
    chk("inval_ack5", 64'(cfg_ack), 64'd1);
    cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd0;
    tick();
    cfg_wr = 1'b0;
    chk("inval_ack2", 64'(cfg_ack), 64'd1);
    tick();
    chk("inval_ack_off", 64'(cfg_ack), 64'd0);
    for (int k = 15; k <= 65; k++) begin
      logic [1:0] e;
      run_to(k);
      e = (((k / 16) % 2) == 1) ? 2'b11 : 2'b00;
      chk("inval_ch_out", 64'(ch_out), 64'(e));
    end

    // Switch sel 0->1 while clk_cpu is high, ch1 divisor 1
    do_reset();
    run_to(1);
    cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd1;
    tick();
    cfg_wr = 1'b0;
    chk("sw_ack", 64'(cfg_ack), 64'd1);
    run_to(20);
    chk("sw_cpu_before", 64'(clk_cpu), 64'd1);
    sel = 3'd1;
    for (int k = 21; k <= 52; k++) begin
      logic e_cpu;
      run_to(k);
      if (k <= 32)      e_cpu = 1'b1;
      else if (k <= 36) e_cpu = 1'b0;
      else              e_cpu = ((((k - 37) / 2) % 2) == 0);
      chk("sw_clk_cpu", 64'(clk_cpu), 64'(e_cpu));
      chk("sw_busy", 64'(busy), 64'((k >= 21) && (k <= 36)));
    end

    // Step mode: three step edges, the second lands inside the pulse
    do_reset();
    sel = 3'd7;
    for (int k = 1; k <= 40; k++) begin
      run_to(k);
      chk("step_clk_cpu", 64'(clk_cpu),
          64'(((k >= 13) && (k <= 16)) || ((k >= 28) && (k <= 31))));
      chk("step_busy", 64'(busy), 64'(k == 1));
      if (k == 10 || k == 13 || k == 25) step = 1'b1;
      if (k == 11 || k == 14 || k == 26) step = 1'b0;
    end

    // Reset asserted while in HOLD
    do_reset();
    run_to(2);
    sel = 3'd1;
    run_to(8);
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_clk_cpu", 64'(clk_cpu), 64'd0);
    rst = 1'b1;
    #1;
    chk("hrst_clkdiv", 64'(clkdiv), 64'd0);
    chk("hrst_ch_en", 64'(ch_en), 64'd0);
    chk("hrst_ch_out", 64'(ch_out), 64'd0);
    chk("hrst_ack", 64'(cfg_ack), 64'd0);
    chk("hrst_clk_cpu", 64'(clk_cpu), 64'd0);
    chk("hrst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    cyc = 0;
    run_to(1);
    chk("post_busy1", 64'(busy), 64'd1);
    chk("post_clkdiv1", 64'(clkdiv), 64'd1);
    run_to(16);
    chk("post_busy16", 64'(busy), 64'd1);
    chk("post_cpu16", 64'(clk_cpu), 64'd0);
    run_to(17);
    chk("post_busy17", 64'(busy), 64'd0);
    chk("post_cpu17", 64'(clk_cpu), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
